// File: rtl/inst_enc_pkg.sv
// Shared RV32I encoding constants, instruction-class enumeration and immediate limits
// for the streaming instruction encoder.
package inst_enc_pkg;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_OPIMM  = 3'd4,
    CLS_JALR   = 3'd5,
    CLS_JAL    = 3'd6,
    CLS_RSVD   = 3'd7
  } inst_class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int SHAMT_MAX = 31;
  localparam int BR_MIN    = -4096;
  localparam int BR_MAX    = 4094;
  localparam int JAL_MIN   = -1048576;
  localparam int JAL_MAX   = 1048574;

  typedef struct packed {
    logic        illegal;
    logic [31:0] inst;
  } enc_entry_t;

endpackage

// File: rtl/inst_enc_fifo.sv
// Synchronous FIFO for encoded entries; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module inst_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder with a small output FIFO.
// Optional immediate range checking is enabled by defining INST_ENC_RANGE_CHECK_EN.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_class,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_illegal,
  output logic [CNT_W-1:0] emit_cnt,
  output logic             err_sticky
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  inst_class_e      cls;
  logic             is_shift, range_bad;
  logic [11:0]      imm_i;
  enc_entry_t       enc_d, head;
  logic             full, empty, push, pop;
  logic [CNT_W-1:0] emit_cnt_q, emit_cnt_d;
  logic             err_sticky_q, err_sticky_d;

  assign cls      = inst_class_e'(in_class);
  assign is_shift = (cls == CLS_OPIMM) && (in_funct3[1:0] == 2'b01);
  assign imm_i    = is_shift ? {in_funct7, in_imm[4:0]} : in_imm[11:0];

`ifdef INST_ENC_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm = $signed(in_imm);

  always_comb begin
    range_bad = 1'b0;
    case (cls)
      CLS_LOAD, CLS_STORE, CLS_JALR: range_bad = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      CLS_OPIMM: range_bad = is_shift ? ((simm < 0) || (simm > SHAMT_MAX))
                                      : ((simm < IMM12_MIN) || (simm > IMM12_MAX));
      CLS_BRANCH: range_bad = (simm < BR_MIN) || (simm > BR_MAX) || in_imm[0];
      CLS_JAL:    range_bad = (simm < JAL_MIN) || (simm > JAL_MAX) || in_imm[0];
      default:    range_bad = 1'b0;
    endcase
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:21];
  assign range_bad     = 1'b0;
`endif

  always_comb begin
    enc_d = '0;
    case (cls)
      CLS_R:      enc_d.inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      CLS_LOAD:   enc_d.inst = {imm_i, in_rs1, in_funct3, in_rd, OP_LOAD};
      CLS_OPIMM:  enc_d.inst = {imm_i, in_rs1, in_funct3, in_rd, OP_OPIMM};
      CLS_JALR:   enc_d.inst = {imm_i, in_rs1, 3'b000, in_rd, OP_JALR};
      CLS_STORE:  enc_d.inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
      CLS_BRANCH: enc_d.inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], OP_BRANCH};
      CLS_JAL:    enc_d.inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      default:    enc_d.illegal = 1'b1;
    endcase
    if (range_bad) begin
      enc_d.illegal = 1'b1;
      enc_d.inst    = '0;
    end
  end

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and in_ready reflects only FIFO fullness (no pass-through when full).
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  inst_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (33)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (enc_d),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_inst    = head.inst;
  assign out_illegal = head.illegal;

  assign emit_cnt_d   = pop ? emit_cnt_q + CNT_ONE : emit_cnt_q;
  assign err_sticky_d = err_sticky_q | (push && enc_d.illegal);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      emit_cnt_q   <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      emit_cnt_q   <= emit_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign emit_cnt   = emit_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder: directed vectors, backpressure, async reset and
// counter wrap, all scored against a field-arithmetic reference model.
module tb_inst_encoder;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int WRAP_N = (1 << CNT_W) + 3;
  localparam int LIMIT  = 200;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_class = '0;
  logic [4:0]       in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]       in_funct3 = '0;
  logic [6:0]       in_funct7 = '0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_inst;
  logic             out_illegal;
  logic [CNT_W-1:0] emit_cnt;
  logic             err_sticky;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [32:0]      exp_q[$];
  logic [CNT_W-1:0] exp_emit = '0;
  logic             exp_err = 1'b0;
  logic [32:0]      head_w, push_w;
  bit               drv_uc = 1'b0;
  logic [32:0]      drv_cw = '0;
  bit               rdone;
  time              t0;
  int               edges[12] = '{-2049, -2048, 2047, 2048, -4096, 4094, 4095, -4098,
                                  1048574, -1048576, 1048576, -1048578};

  inst_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_illegal(out_illegal), .emit_cnt(emit_cnt), .err_sticky(err_sticky)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint fld(input longint v, input int lo, input int n);
    return (v >> lo) & ((longint'(1) << n) - 1);
  endfunction

  // Reference model: places each instruction field by weight, straight from the RV32I layouts.
  function automatic logic [32:0] model(input logic [2:0] c, input logic [4:0] rd, rs1, rs2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm);
    longint w, im, rdv, s1, s2, f3v, f7v, i12;
    int     si;
    bit     ill, shift;
    si = imm; im = si; rdv = rd; s1 = rs1; s2 = rs2; f3v = f3; f7v = f7;
    w = 0; ill = 0;
    shift = (c == 3'd4) && (f3 == 3'd1 || f3 == 3'd5);
    i12 = shift ? (f7v * 32 + fld(im, 0, 5)) : fld(im, 0, 12);
    case (c)
      3'd0: w = (f7v << 25) + (s2 << 20) + (s1 << 15) + (f3v << 12) + (rdv << 7) + 'h33;
      3'd1: w = (i12 << 20) + (s1 << 15) + (f3v << 12) + (rdv << 7) + 'h03;
      3'd2: w = (fld(im, 5, 7) << 25) + (s2 << 20) + (s1 << 15) + (f3v << 12)
              + (fld(im, 0, 5) << 7) + 'h23;
      3'd3: w = (fld(im, 12, 1) << 31) + (fld(im, 5, 6) << 25) + (s2 << 20) + (s1 << 15)
              + (f3v << 12) + (fld(im, 1, 4) << 8) + (fld(im, 11, 1) << 7) + 'h63;
      3'd4: w = (i12 << 20) + (s1 << 15) + (f3v << 12) + (rdv << 7) + 'h13;
      3'd5: w = (i12 << 20) + (s1 << 15) + (rdv << 7) + 'h67;
      3'd6: w = (fld(im, 20, 1) << 31) + (fld(im, 1, 10) << 21) + (fld(im, 11, 1) << 20)
              + (fld(im, 12, 8) << 12) + (rdv << 7) + 'h6F;
      default: ill = 1;
    endcase
`ifdef INST_ENC_RANGE_CHECK_EN
    case (c)
      3'd1, 3'd2, 3'd5: if (si < -2048 || si > 2047) ill = 1;
      3'd4: if (shift ? (si < 0 || si > 31) : (si < -2048 || si > 2047)) ill = 1;
      3'd3: if (si < -4096 || si > 4094 || (si % 2) != 0) ill = 1;
      3'd6: if (si < -1048576 || si > 1048574 || (si % 2) != 0) ill = 1;
      default: ;
    endcase
`endif
    if (ill) w = 0;
    return {ill, w[31:0]};
  endfunction

  // scoreboard / monitor, sampled on the falling edge
  always begin
    @(negedge clk or negedge reset_n);
    if (!reset_n) begin
      exp_q.delete();
      exp_emit = '0;
      exp_err  = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_inst", out_inst, 0);
      check("rst_out_illegal", out_illegal, 0);
      check("rst_emit_cnt", emit_cnt, 0);
      check("rst_err_sticky", err_sticky, 0);
    end else begin
      check("in_ready", in_ready, exp_q.size() < DEPTH);
      check("out_valid", out_valid, exp_q.size() != 0);
      check("emit_cnt", emit_cnt, exp_emit);
      check("err_sticky", err_sticky, exp_err);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        head_w = exp_q.pop_front();
        check("out_inst", out_inst, head_w[31:0]);
        check("out_illegal", out_illegal, head_w[32]);
        exp_emit++;
      end
      if (in_valid && in_ready) begin
        push_w = drv_uc ? drv_cw
                        : model(in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        exp_q.push_back(push_w);
        if (push_w[32]) exp_err = 1'b1;
      end
    end
  end

  // drivers
  task automatic do_reset();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic send(input logic [2:0] c, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input bit uc, input logic [32:0] cw);
    bit ok;
    in_valid = 1'b1; in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; drv_uc = uc; drv_cw = cw;
    ok = 0;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge clk);
      if (reset_n && in_ready) begin
        ok = 1;
        break;
      end
    end
    check("send_timeout", ok, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drv_uc = 1'b0;
  endtask

  function automatic logic [31:0] rand_imm();
    int t;
    case ($urandom_range(0, 4))
      0: t = int'($urandom_range(0, 31));
      1: t = int'($urandom_range(0, 8191)) - 4096;
      2: t = edges[$urandom_range(0, 11)];
      3: t = int'($urandom);
      default: t = int'($urandom_range(0, 2097151)) - 1048576;
    endcase
    return t;
  endfunction

  task automatic send_rand();
    send(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
         3'($urandom), 7'($urandom), rand_imm(), 1'b0, '0);
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    do_reset();
    out_ready = 1'b1;

    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, {1'b0, 32'h002081B3});
    send(3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd8, 1'b1, {1'b0, 32'h00812283});
    send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, {1'b0, 32'h00000463});
    send(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 1'b1, {1'b0, 32'hFFDFF0EF});
    send(3'd4, 5'd0, 5'd0, 5'd0, 3'd5, 7'h20, 32'd3, 1'b1, {1'b0, 32'h40305013});
    send(3'd7, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFF, 1'b1, {1'b1, 32'h0});
`ifdef INST_ENC_RANGE_CHECK_EN
    send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, {1'b1, 32'h0});
`else
    send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, {1'b0, 32'h80000013});
`endif
    repeat (40) send_rand();
    drain();

    // backpressure: fifth push is held until the consumer resumes
    do_reset();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(3'd0, 5'(i + 1), 5'(i), 5'(i + 2), 3'd0, 7'd0, 32'd0, 1'b0, '0);
      end
      begin
        repeat (12) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    @(negedge clk);
    check("emit_after_5", emit_cnt, 5);

    // random consumer stalls
    rdone = 0;
    fork
      begin
        repeat (300) send_rand();
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // asynchronous reset mid-cycle with three entries queued, one illegal
    do_reset();
    out_ready = 1'b0;
    send(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, '0);
    send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, '0);
    send(3'd1, 5'd4, 5'd5, 5'd0, 3'd2, 7'd0, 32'd16, 1'b0, '0);
    @(negedge clk);
    check("pre_rst_err", err_sticky, 1);
    #3 reset_n = 1'b0;
    #4;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_post_rst", in_ready, 1);
    check("out_valid_post_rst", out_valid, 0);
    @(posedge clk);
    #1;

    // counter wrap with continuous flow
    do_reset();
    out_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < WRAP_N; i++) send_rand();
    check("no_stall", 32'(($time - t0) / 10), WRAP_N);
    drain();
    @(negedge clk);
    check("emit_wrap", emit_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RV32I instruction encoder, the inverse of the opcode-to-control decode path.
- Accepts an instruction class plus register, funct and immediate fields over a valid/ready input, and packs them into a 32-bit instruction word.
- Buffers encoded words in a small FIFO and presents them over a valid/ready output.
- Used by the instruction-memory loader and by testbench stimulus generation to produce words the CPU decodes.

Parameters:
- FIFO_DEPTH, 4, output buffer entries; power of two, minimum 2.
- CNT_W, 16, width of the emitted-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept.
- in_class  in  3  0=R, 1=LOAD, 2=STORE, 3=BRANCH, 4=OPIMM, 5=JALR, 6=JAL, 7=reserved.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7; for OPIMM shifts, the upper immediate bits.
- in_imm  in  32  signed immediate; byte offset for BRANCH and JAL.
- out_valid  out  1  head word valid.
- out_ready  in  1  consumer accepts.
- out_inst  out  32  encoded word.
- out_illegal  out  1  head word is illegal.
- emit_cnt  out  CNT_W  count of words popped; wraps.
- err_sticky  out  1  set when an illegal word is pushed; cleared only by reset.

Behaviour:
- Reset (asynchronous, reset_n=0): FIFO empty, out_valid=0, out_inst=0, out_illegal=0, emit_cnt=0, err_sticky=0. Reset may assert at any cycle; all in-flight entries are discarded.
- Push: occurs when in_valid && in_ready. in_ready = !full. No pass-through when full, even if a pop happens in the same cycle.
- Pop: occurs when out_valid && out_ready. out_valid = !empty. out_inst and out_illegal are driven from the head entry, registered. Simultaneous push and pop is allowed when not full; occupancy is unchanged.
- Latency: a word pushed in cycle N is visible on out_valid in cycle N+1 at the earliest. Order is strict FIFO.
- Encoding is combinational at push time. Opcodes:
  - R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011, OPIMM 0010011, JALR 1100111, JAL 1101111.
- Field layouts (standard RV32I):
  - R: f7|rs2|rs1|f3|rd|op.
  - LOAD, OPIMM, JALR: imm[11:0]|rs1|f3|rd|op. JALR forces f3=000.
  - OPIMM with f3=001 or 101: imm[31:20] = {in_funct7, in_imm[4:0]}.
  - STORE: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Unused fields are ignored and their bit positions are taken from the layout only.
- in_class=7: entry is stored with inst=0, illegal=1, err_sticky set.
- emit_cnt: increments on each pop and wraps from all-ones to 0.
- Pointers: wrap modulo FIFO_DEPTH. An extra occupancy bit distinguishes full from empty.

Optional Feature:
- Macro INST_ENC_RANGE_CHECK_EN.
- Defined: a push is flagged illegal (inst stored as 0, illegal=1, err_sticky set) when any of these hold:
  - LOAD, STORE, JALR, or non-shift OPIMM imm is outside -2048..2047.
  - OPIMM shift imm is outside 0..31.
  - BRANCH imm is outside -4096..4094, or odd.
  - JAL imm is outside -1048576..1048574, or odd.
- Undefined: no range check. Immediates are silently truncated to their field bits, and only in_class=7 produces illegal.

Decomposition:
- Package inst_enc_pkg holds:
  - the seven 7-bit opcode constants;
  - the 3-bit class enumeration;
  - the immediate range limit constants.
- One sub-module, inst_enc_fifo: parameterised synchronous FIFO storing 33-bit entries {illegal, inst}, with full and empty outputs and the asynchronous active-low reset.

Test Plan:
- R, rd=3, rs1=1, rs2=2, f3=0, f7=0, out_ready=1 -> out_inst=0x002081B3 one cycle after push, out_illegal=0, emit_cnt=1.
- LOAD, rd=5, rs1=2, f3=010, imm=8 -> 0x00812283. BRANCH, rs1=rs2=0, f3=000, imm=8 -> 0x00000463. JAL, rd=1, imm=-4 -> 0xFFDFF0EF.
- out_ready=0, push 5 back-to-back R words -> in_ready=0 after the 4th push and the 5th is held. Then release out_ready -> the 5 words emerge in order, emit_cnt=5.
- in_class=7 -> out_inst=0, out_illegal=1, err_sticky=1. With INST_ENC_RANGE_CHECK_EN defined, OPIMM imm=2048 -> illegal. Without the macro, the same request gives 0x80000013 with rd=rs1=f3=0.
- Fill FIFO with 3 entries, pulse reset_n low mid-cycle -> out_valid=0, emit_cnt=0, err_sticky=0 immediately, in_ready=1 after release.
- Continuous push and pop with out_ready=1 for 2^CNT_W+3 words -> no stall and emit_cnt wraps to 3.
